// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: BCD MM:SS stopwatch advanced by rising edges of a slow divided clock.
//
// Ports:
//   clkin      system clock; all state updates on its rising edge
//   clr_n      asynchronous active-low reset
//   tick_in    divided slow clock, treated as asynchronous data; one count per rising edge
//   btn_start  debounced start/stop button (asynchronous level); rising edge toggles RUN/PAUSE
//   btn_clear  debounced clear button (asynchronous level); while high forces IDLE and 00:00
//   sec_ones   BCD seconds units
//   sec_tens   BCD seconds tens
//   min_ones   BCD minutes units
//   min_tens   BCD minutes tens
//   running    high while in RUN
//   wrap       one-cycle pulse when MIN_LIMIT:SEC_LIMIT rolls over to 00:00
module stopwatch_bcd_counter #(
    parameter int MIN_LIMIT = 59,
    parameter int SEC_LIMIT = 59
) (
    input  logic       clkin,
    input  logic       clr_n,
    input  logic       tick_in,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    // Limits split into BCD digits so the end-of-range test is a plain digit compare.
    localparam logic [3:0] SEC_T = 4'(SEC_LIMIT / 10);
    localparam logic [3:0] SEC_O = 4'(SEC_LIMIT % 10);
    localparam logic [3:0] MIN_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_LIMIT % 10);

    logic       tick_s1_q, tick_s2_q, tick_prev_q;
    logic       start_s1_q, start_s2_q, start_prev_q;
    logic       clr_s1_q, clr_s2_q;
    logic [1:0] state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       running_q, running_d;
    logic       wrap_q, wrap_d;
    logic       tick_p, start_p, sec_end, min_end, inc;

    // Two-flop synchronisers plus a history flop for edge detection on tick and start.
    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            tick_s1_q    <= 1'b0;
            tick_s2_q    <= 1'b0;
            tick_prev_q  <= 1'b0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            clr_s1_q     <= 1'b0;
            clr_s2_q     <= 1'b0;
        end else begin
            tick_s1_q    <= tick_in;
            tick_s2_q    <= tick_s1_q;
            tick_prev_q  <= tick_s2_q;
            start_s1_q   <= btn_start;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            clr_s1_q     <= btn_clear;
            clr_s2_q     <= clr_s1_q;
        end
    end

    always_comb begin
        tick_p     = tick_s2_q & ~tick_prev_q;
        start_p    = start_s2_q & ~start_prev_q;
        sec_end    = (sec_tens_q == SEC_T) && (sec_ones_q == SEC_O);
        min_end    = (min_tens_q == MIN_T) && (min_ones_q == MIN_O);
        // Tick is judged against the pre-transition state, so RUN+start+tick still counts.
        inc        = tick_p && (state_q == RUN);
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clr_s2_q) begin
            state_d    = IDLE;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else begin
            if (start_p)
                state_d = (state_q == RUN) ? PAUSE : RUN;
            else if (state_q != IDLE && state_q != RUN && state_q != PAUSE)
                state_d = IDLE;
            if (inc) begin
                if (sec_end) begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    if (min_end) begin
                        min_ones_d = 4'd0;
                        min_tens_d = 4'd0;
                        wrap_d     = 1'b1;
                    end else if (min_ones_q == 4'd9) begin
                        min_ones_d = 4'd0;
                        min_tens_d = min_tens_q + 4'd1;
                    end else begin
                        min_ones_d = min_ones_q + 4'd1;
                    end
                end else if (sec_ones_q == 4'd9) begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign running  = running_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: checks two stopwatch instances (59:59 and 01:03 limits) against a total-seconds model.
module tb_stopwatch_bcd_counter;

    localparam int SLA = 59, MLA = 59, SLB = 3, MLB = 1;
    localparam int PA = (MLA + 1) * (SLA + 1);
    localparam int PB = (MLB + 1) * (SLB + 1);
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic clk = 1'b0;
    logic clr_n = 1'b1;
    logic tick_in = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
    logic [3:0] so_a, st_a, mo_a, mt_a, so_b, st_b, mo_b, mt_b;
    logic running_a, wrap_a, running_b, wrap_b;

    int tests = 0, fails = 0;
    int ca = 0, cb = 0, mstate = M_IDLE;
    bit mclr = 0;

    always #5 clk = ~clk;

    stopwatch_bcd_counter u_a (
        .clkin(clk), .clr_n(clr_n), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
        .sec_ones(so_a), .sec_tens(st_a), .min_ones(mo_a), .min_tens(mt_a),
        .running(running_a), .wrap(wrap_a)
    );

    stopwatch_bcd_counter #(.MIN_LIMIT(MLB), .SEC_LIMIT(SLB)) u_b (
        .clkin(clk), .clr_n(clr_n), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
        .sec_ones(so_b), .sec_tens(st_b), .min_ones(mo_b), .min_tens(mt_b),
        .running(running_b), .wrap(wrap_b)
    );

    wire [15:0] disp_a = {mt_a, mo_a, st_a, so_a};
    wire [15:0] disp_b = {mt_b, mo_b, st_b, so_b};

    function automatic logic [15:0] bcd(input int c, input int sl);
        int m, s;
        m = c / (sl + 1);
        s = c % (sl + 1);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_disp_a"}, disp_a, bcd(ca, SLA));
        chk({tag, "_disp_b"}, disp_b, bcd(cb, SLB));
        chk({tag, "_run_a"}, 16'(running_a), 16'(mstate == M_RUN));
        chk({tag, "_run_b"}, 16'(running_b), 16'(mstate == M_RUN));
        chk({tag, "_wrap_a"}, 16'(wrap_a), 16'(0));
        chk({tag, "_wrap_b"}, 16'(wrap_b), 16'(0));
    endtask

    // One input event: tick and/or start rising together, random high/low times.
    // Digits must be unchanged two edges after the rise and updated on the third.
    task automatic ev(input bit t, input bit s);
        int h, l, wa, wb;
        bit inc, ewa, ewb, orun, nrun;
        logic [15:0] oa, ob, na, nb;
        h = $urandom_range(1, 4);
        l = $urandom_range(3, 5);
        oa = bcd(ca, SLA);
        ob = bcd(cb, SLB);
        orun = (mstate == M_RUN);
        inc = t && !mclr && mstate == M_RUN;
        if (inc) begin
            ca = (ca + 1) % PA;
            cb = (cb + 1) % PB;
        end
        ewa = inc && ca == 0;
        ewb = inc && cb == 0;
        if (s && !mclr) mstate = (mstate == M_RUN) ? M_PAUSE : M_RUN;
        nrun = (mstate == M_RUN);
        na = bcd(ca, SLA);
        nb = bcd(cb, SLB);
        tick_in = t;
        btn_start = s;
        wa = 0;
        wb = 0;
        for (int k = 1; k <= h + l; k++) begin
            step();
            wa += int'(wrap_a);
            wb += int'(wrap_b);
            if (k == 2) begin
                chk("lat_hold_a", disp_a, oa);
                chk("lat_hold_b", disp_b, ob);
                chk("lat_hold_run", 16'(running_a), 16'(orun));
            end
            if (k == 3) begin
                chk("lat_upd_a", disp_a, na);
                chk("lat_upd_b", disp_b, nb);
                chk("lat_upd_run", 16'(running_a), 16'(nrun));
                chk("wrap_edge_a", 16'(wrap_a), 16'(ewa));
                chk("wrap_edge_b", 16'(wrap_b), 16'(ewb));
            end
            if (k == h) begin
                tick_in = 1'b0;
                btn_start = 1'b0;
            end
        end
        chk("wrap_len_a", 16'(wa), 16'(ewa));
        chk("wrap_len_b", 16'(wb), 16'(ewb));
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (ca != target && guard < PA + 5) begin
            ev(1, 0);
            guard++;
        end
        chk("run_to_reached", 16'(ca == target), 16'(1));
    endtask

    task automatic clear_on();
        btn_clear = 1'b1;
        repeat (3) step();
        mclr = 1;
        ca = 0;
        cb = 0;
        mstate = M_IDLE;
    endtask

    task automatic clear_off();
        btn_clear = 1'b0;
        repeat (3) step();
        mclr = 0;
    endtask

    initial begin
        #2 clr_n = 1'b0;
        repeat (6) begin
            tick_in = ~tick_in;
            step();
        end
        tick_in = 1'b0;
        check_all("reset");
        chk("reset_const_a", disp_a, 16'h0000);
        clr_n = 1'b1;
        repeat (2) step();
        repeat (5) ev(1, 0);
        check_all("idle_no_start");
        chk("idle_const", disp_a, 16'h0000);

        ev(0, 1);
        repeat (12) ev(1, 0);
        check_all("basic");
        chk("basic_const", disp_a, 16'h0012);
        chk("basic_running", 16'(running_a), 16'(1));

        run_to(59);
        chk("c0059", disp_a, 16'h0059);
        ev(1, 0);
        chk("c0100", disp_a, 16'h0100);
        run_to(599);
        chk("c0959", disp_a, 16'h0959);
        ev(1, 0);
        chk("c1000", disp_a, 16'h1000);
        run_to(PA - 1);
        chk("c5959", disp_a, 16'h5959);
        ev(1, 0);
        chk("wrap_zero", disp_a, 16'h0000);
        check_all("after_wrap");

        repeat (5) ev(1, 0);
        chk("p0005", disp_a, 16'h0005);
        ev(1, 1);
        chk("p_run_start_tick", disp_a, 16'h0006);
        chk("p_paused", 16'(running_a), 16'(0));
        repeat (3) ev(1, 0);
        chk("p_hold", disp_a, 16'h0006);
        ev(1, 1);
        chk("p_resume_no_count", disp_a, 16'h0006);
        chk("p_resumed", 16'(running_a), 16'(1));
        ev(1, 0);
        chk("p0007", disp_a, 16'h0007);
        check_all("pause");

        run_to(30);
        chk("c0030", disp_a, 16'h0030);
        clear_on();
        repeat (3) ev(1, 0);
        ev(0, 1);
        check_all("clear_held");
        chk("clear_const", disp_a, 16'h0000);
        clear_off();
        ev(0, 1);
        ev(1, 0);
        chk("clear_then_one", disp_a, 16'h0001);
        check_all("post_clear");

        repeat (7) ev(1, 0);
        @(negedge clk);
        #2 clr_n = 1'b0;
        ca = 0;
        cb = 0;
        mstate = M_IDLE;
        #1 check_all("async_reset");
        step();
        clr_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 11))
                0: ev(0, 1);
                1: ev(1, 1);
                2: repeat ($urandom_range(1, 6)) step();
                3: begin
                    clear_on();
                    repeat ($urandom_range(0, 3)) step();
                    clear_off();
                end
                default: ev(1, 0);
            endcase
        end
        check_all("random_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
